mux_sel_sequencer: RTL and testbench
====================================

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

Parameters
REQ-001 DWELL_W, 8, width of the dwell count.

Interface
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 en_i  input  1  scan enable.
REQ-005 mask_i  input  4  channel enable mask; bit n enables channel n.
REQ-006 dwell_i  input  DWELL_W  cycles per channel minus 1.
REQ-007 q_i  input  1  output of the downstream 4:1 mux.
REQ-008 sel_o  output  2  channel select; drives the mux select input.
REQ-009 valid_o  output  1  high while sel_o addresses an enabled channel under scan.
REQ-010 sample_o  output  4  last captured q_i per channel; bit n belongs to channel n.
REQ-011 sample_stb_o  output  1  one-cycle pulse when a sample is captured.
REQ-012 frame_o  output  1  one-cycle pulse when the scan wraps.

Function
REQ-013 FSM states: IDLE and SCAN; all outputs registered.
REQ-014 IDLE->SCAN: en_i=1 and mask_i!=0; on that edge, sel_o<=lowest enabled channel, cnt<=0, dwell_q<=dwell_i, valid_o<=1.
REQ-015 SCAN->IDLE: en_i=0 or mask_i=0; valid_o<=0, cnt<=0; sel_o and sample_o hold.
REQ-016 In SCAN with cnt<dwell_q and the current channel enabled: cnt<=cnt+1.
REQ-017 Dwell end (SCAN, cnt==dwell_q, current channel enabled): sample_o[sel_o]<=q_i, sample_stb_o<=1, sel_o<=next enabled channel, cnt<=0, dwell_q<=dwell_i.
REQ-018 Channel residency: dwell_q+1 cycles; dwell_i=0 gives 1 cycle per channel.
REQ-019 Next channel: circular search upward from sel_o+1 (3 wraps to 0); first enabled bit of mask_i wins.
REQ-020 frame_o<=1 on the dwell-end edge when next channel index <= current index (wrap); with one enabled channel, frame_o pulses every dwell end.
REQ-021 Current channel masked mid-dwell (SCAN, mask_i[sel_o]=0, mask_i!=0): next edge advances per REQ-019; no sample, no sample_stb_o; cnt<=0; frame_o per REQ-020.
REQ-022 dwell_i changes affect only the next channel start; dwell_q is stable within a dwell.
REQ-023 Priority, highest first: rst_i, exit to IDLE (REQ-015), masked-channel skip (REQ-021), dwell end (REQ-017), count (REQ-016).
REQ-024 sample_stb_o and frame_o are low on every edge not named in REQ-017, REQ-020 and REQ-021.
REQ-025 q_i is sampled only at dwell end; mux settling is covered by dwell_q>=1.

Reset
REQ-026 On rst_i=1 at an edge: state=IDLE, sel_o=0, valid_o=0, sample_o=0, sample_stb_o=0, frame_o=0, cnt=0, dwell_q=0.
REQ-027 Reset mid-dwell discards the pending sample; the first post-reset edge with en_i=1 behaves per REQ-014.

Structure
REQ-028 Shared package mux_seq_pkg holds the state enum (IDLE, SCAN) and constant NUM_CH=4.
REQ-029 One combinational sub-module mux_seq_next_ch takes (cur[1:0], mask[3:0]) and returns next[1:0] and wrap, per REQ-019 and REQ-020.
REQ-030 Top level holds the FSM, cnt, dwell_q and output registers; the sub-module is instantiated once.

Verification
REQ-031 mask=1111, dwell=2, en=1, q_i=sel-dependent pattern 1,0,1,1 -> sel_o 0,1,2,3 each held 3 cycles; sample_o=1101 after first frame; frame_o on the 3->0 edge.
REQ-032 mask=1010, dwell=0 -> sel_o alternates 1,3 every cycle; frame_o on each 3->1 edge; sample_o bits 0 and 2 stay 0.
REQ-033 mask=1111, dwell=5; clear mask[1] at cycle 2 of channel 1 -> next edge sel_o=2; no sample_stb_o; sample_o[1] unchanged.
REQ-034 Deassert en_i mid-dwell on channel 2 -> valid_o=0 next cycle, sel_o holds 2; re-enable -> sel_o restarts at the lowest enabled channel with cnt=0.
REQ-035 rst_i pulse mid-scan with sample_o=1111 -> all outputs reach reset values on that edge; no strobe.
REQ-036 Change dwell_i 2->7 mid-dwell -> the current channel still holds 3 cycles; the next channel holds 8.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the 4-channel mux select sequencer.
package mux_seq_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/mux_seq_next_ch.sv
// Circular next-enabled-channel search starting above cur; wrap flags a non-increasing step.
module mux_seq_next_ch
  import mux_seq_pkg::*;
(
  input  logic [1:0] cur,
  input  logic [3:0] mask,
  output logic [1:0] next,
  output logic       wrap
);

  logic [1:0] w_idx;

  // Walk from farthest to nearest so the nearest enabled channel is the last write;
  // offset NUM_CH lands back on cur, which covers the single-channel case.
  always_comb begin
    next  = cur;
    w_idx = cur;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = cur + 2'(k);
      if (mask[w_idx]) next = w_idx;
    end
    wrap = (mask != 4'b0000) && (next <= cur);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scans enabled channels of a downstream 4:1 mux, dwelling a programmable time on each and capturing q_i.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [3:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               q_i,
  output logic [1:0]         sel_o,
  output logic               valid_o,
  output logic [3:0]         sample_o,
  output logic               sample_stb_o,
  output logic               frame_o
);

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell_q, w_dwell_q_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic               r_valid, w_valid_nxt;
  logic [3:0]         r_sample, w_sample_nxt;
  logic               r_stb, w_stb_nxt;
  logic               r_frame, w_frame_nxt;

  logic [1:0] w_cur;
  logic [1:0] w_next;
  logic       w_wrap;
  logic       w_run;

  // From IDLE the search starts above channel 3, which yields the lowest enabled channel.
  assign w_cur = (r_state == IDLE) ? 2'd3 : r_sel;
  assign w_run = en_i && (mask_i != 4'b0000);

  mux_seq_next_ch u_next_ch (
    .cur  (w_cur),
    .mask (mask_i),
    .next (w_next),
    .wrap (w_wrap)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dwell_q_nxt = r_dwell_q;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_sample_nxt  = r_sample;
    w_stb_nxt     = 1'b0;
    w_frame_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_run) begin
          w_state_nxt   = SCAN;
          w_sel_nxt     = w_next;
          w_cnt_nxt     = '0;
          w_dwell_q_nxt = dwell_i;
          w_valid_nxt   = 1'b1;
        end
      end
      SCAN: begin
        if (!w_run) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end else if (!mask_i[r_sel]) begin
          w_sel_nxt     = w_next;
          w_cnt_nxt     = '0;
          w_dwell_q_nxt = dwell_i;
          w_frame_nxt   = w_wrap;
        end else if (r_cnt == r_dwell_q) begin
          w_sample_nxt[r_sel] = q_i;
          w_stb_nxt           = 1'b1;
          w_sel_nxt           = w_next;
          w_cnt_nxt           = '0;
          w_dwell_q_nxt       = dwell_i;
          w_frame_nxt         = w_wrap;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dwell_q <= '0;
      r_sel     <= 2'd0;
      r_valid   <= 1'b0;
      r_sample  <= 4'b0000;
      r_stb     <= 1'b0;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dwell_q <= w_dwell_q_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_sample  <= w_sample_nxt;
      r_stb     <= w_stb_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign sel_o        = r_sel;
  assign valid_o      = r_valid;
  assign sample_o     = r_sample;
  assign sample_stb_o = r_stb;
  assign frame_o      = r_frame;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: vector table, directed corner sequences, random scan vs. reference model.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, q;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic [1:0] sel;
  logic       valid, stb, frame;
  logic [3:0] sample;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .mask_i       (mask),
    .dwell_i      (dwell),
    .q_i          (q),
    .sel_o        (sel),
    .valid_o      (valid),
    .sample_o     (sample),
    .sample_stb_o (stb),
    .frame_o      (frame)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which channel is selected, how long it has been held, what was captured.
  bit         m_scan  = 1'b0;
  bit         m_valid = 1'b0;
  int         m_sel   = 0;
  int         m_cnt   = 0;
  int         m_dq    = 0;
  logic [3:0] m_sample = 4'b0000;
  bit         m_stb   = 1'b0;
  bit         m_frame = 1'b0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic       q;
    logic [1:0] e_sel;
    logic       e_valid;
    logic [3:0] e_sample;
    logic       e_stb;
    logic       e_frame;
  } vec_t;

  vec_t tbl[8];

  function automatic int lowest_ch(logic [3:0] mk);
    for (int i = 0; i < 4; i++) if (mk[i]) return i;
    return 0;
  endfunction

  function automatic int next_ch(int cur, logic [3:0] mk);
    for (int k = 1; k <= 4; k++) if (mk[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  task automatic model_step();
    int  nx;
    bit  dwell_end;
    m_stb   = 1'b0;
    m_frame = 1'b0;
    if (rst) begin
      m_scan = 1'b0; m_valid = 1'b0; m_sel = 0; m_cnt = 0; m_dq = 0; m_sample = 4'b0000;
    end else if (!m_scan) begin
      if (en && mask != 4'b0000) begin
        m_scan = 1'b1; m_valid = 1'b1; m_sel = lowest_ch(mask); m_cnt = 0; m_dq = int'(dwell);
      end
    end else if (!en || mask == 4'b0000) begin
      m_scan = 1'b0; m_valid = 1'b0; m_cnt = 0;
    end else begin
      dwell_end = mask[m_sel] && (m_cnt == m_dq);
      if (!mask[m_sel] || dwell_end) begin
        nx = next_ch(m_sel, mask);
        if (dwell_end) begin
          m_sample[m_sel] = q;
          m_stb = 1'b1;
        end
        m_frame = (nx <= m_sel);
        m_sel   = nx;
        m_cnt   = 0;
        m_dq    = int'(dwell);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs in force, then compare all outputs.
  task automatic cycle();
    logic [8:0] exp_v;
    @(posedge clk);
    model_step();
    #1;
    exp_v = {2'(m_sel), m_valid, m_sample, m_stb, m_frame};
    check("model_outputs", {23'd0, sel, valid, sample, stb, frame}, {23'd0, exp_v});
  endtask

  task automatic set_in(input logic r, input logic e, input logic [3:0] mk,
                        input logic [7:0] dw, input logic qq);
    rst = r; en = e; mask = mk; dwell = dw; q = qq;
  endtask

  int r0, r1;
  logic [3:0] pat;

  initial begin
    set_in(1'b1, 1'b0, 4'h0, 8'd0, 1'b0);

    // Alternating two-channel scan with dwell 0, then exit and a zero-mask enable.
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'b1010, 8'd0, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'b1010, 8'd0, 1'b1, 2'd3, 1'b1, 4'b0010, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'b1010, 8'd0, 1'b0, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'b1010, 8'd0, 1'b0, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 4'b1010, 8'd0, 1'b1, 2'd1, 1'b1, 4'b1000, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'b1010, 8'd0, 1'b1, 2'd1, 1'b0, 4'b1000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 4'b0000, 8'd0, 1'b1, 2'd1, 1'b0, 4'b1000, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].mask, tbl[i].dwell, tbl[i].q);
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("vec%0d", i), {23'd0, sel, valid, sample, stb, frame},
            {23'd0, tbl[i].e_sel, tbl[i].e_valid, tbl[i].e_sample, tbl[i].e_stb, tbl[i].e_frame});
    end

    // Full 4-channel frame with dwell 2 and per-channel pattern 1,0,1,1.
    set_in(1'b1, 1'b0, 4'h0, 8'd0, 1'b0);
    cycle();
    pat = 4'b1101;
    for (int i = 0; i < 13; i++) begin
      set_in(1'b0, 1'b1, 4'b1111, 8'd2, pat[sel]);
      cycle();
    end
    check("frame1_sample", {28'd0, sample}, 32'hD);
    check("frame1_wrap", {31'd0, frame}, 32'd1);
    check("frame1_sel", {30'd0, sel}, 32'd0);

    // Fill every channel with 1, then reset mid-scan.
    for (int i = 0; i < 14; i++) begin
      set_in(1'b0, 1'b1, 4'b1111, 8'd2, 1'b1);
      cycle();
    end
    check("all_ones", {28'd0, sample}, 32'hF);
    set_in(1'b1, 1'b1, 4'b1111, 8'd2, 1'b1);
    cycle();
    check("reset_outputs", {23'd0, sel, valid, sample, stb, frame}, 32'd0);

    // Mask channel 1 away part-way through its dwell.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b1, 4'b1111, 8'd5, 1'b1);
      cycle();
    end
    check("pre_skip_sel", {30'd0, sel}, 32'd1);
    set_in(1'b0, 1'b1, 4'b1101, 8'd5, 1'b1);
    cycle();
    check("skip_sel", {30'd0, sel}, 32'd2);
    check("skip_no_stb", {31'd0, stb}, 32'd0);
    check("skip_keep_s1", {31'd0, sample[1]}, 32'd0);

    // Drop enable while on channel 2, then re-enable with a new mask.
    cycle();
    cycle();
    set_in(1'b0, 1'b0, 4'b1101, 8'd5, 1'b1);
    cycle();
    check("exit_valid", {31'd0, valid}, 32'd0);
    check("exit_sel_hold", {30'd0, sel}, 32'd2);
    set_in(1'b0, 1'b1, 4'b1110, 8'd5, 1'b0);
    cycle();
    check("reenter_sel", {30'd0, sel}, 32'd1);
    for (int i = 0; i < 7; i++) cycle();

    // Dwell change mid-dwell only affects the following channel.
    set_in(1'b1, 1'b0, 4'b0011, 8'd2, 1'b0);
    cycle();
    set_in(1'b0, 1'b1, 4'b0011, 8'd2, 1'b0);
    cycle();
    dwell = 8'd7;
    r0 = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sel != 2'd0) break;
      r0++;
    end
    r1 = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sel != 2'd1) break;
      r1++;
    end
    check("dwell_old_residency", r0, 32'd3);
    check("dwell_new_residency", r1, 32'd8);

    // Random scan traffic against the reference model.
    mask = 4'b1111;
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      dwell = 8'($urandom_range(0, 3));
      q     = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
